// File: rtl/if_pipe_ctrl_if.sv
// if_pipe_ctrl_if: the fetch-controller request inputs and the stage
// pause/flush controls, bundled as one port.
// master drives the requests, slave is the controller that answers them.
interface if_pipe_ctrl_if;
  logic backend_stall;
  logic icache_busy;
  logic ovr_req;
  logic redirect_valid;
  logic redirect_ds;
  logic ds_in_if2;
  logic pause_pc;
  logic pause_if12;
  logic pause_if23;
  logic flush_if12;
  logic flush_if23;
  logic pc_load;
  logic rescue_ds;
  logic miss_timeout;

  modport master (
    output backend_stall, icache_busy, ovr_req, redirect_valid, redirect_ds, ds_in_if2,
    input  pause_pc, pause_if12, pause_if23, flush_if12, flush_if23, pc_load, rescue_ds,
           miss_timeout
  );

  modport slave (
    input  backend_stall, icache_busy, ovr_req, redirect_valid, redirect_ds, ds_in_if2,
    output pause_pc, pause_if12, pause_if23, flush_if12, flush_if23, pc_load, rescue_ds,
           miss_timeout
  );
endinterface

// File: rtl/if_pipe_ctrl.sv
// if_pipe_ctrl: sequences pause/flush of PC, IF1/2 and IF2/3 for the
// instruction-fetch front end (back-pressure, I-cache miss, overrun replay,
// backend redirect with delay-slot rescue).
// Optional feature: define IF_CTRL_PERF_EN to add stall/miss/redirect
// cycle counters on ports perf_stall, perf_miss, perf_redir.
module if_pipe_ctrl #(
  parameter int unsigned REDIR_BUBBLES  = 2,
  parameter int unsigned MISS_TIMEOUT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  if_pipe_ctrl_if.slave bus
`ifdef IF_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_miss,
  output logic [31:0]   perf_redir
`endif
);

  typedef enum logic [1:0] {RUN, MISS, OVR_HOLD, REDIR} state_t;

  localparam logic [2:0]                BUB_LOAD = 3'(REDIR_BUBBLES - 1);
  localparam logic [MISS_TIMEOUT_W-1:0] MISS_ONE = MISS_TIMEOUT_W'(1);

  state_t                    state, state_nxt;
  logic [2:0]                bub_cnt, bub_nxt;
  logic [MISS_TIMEOUT_W-1:0] miss_cnt, miss_nxt;
  logic                      ovr_rel, ovr_rel_nxt;
  logic                      timeout_q, timeout_nxt;
  logic                      p_pc, p_if12, p_if23, f_if12, f_if23, load, rescue;

  // State, counters and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      bub_cnt   <= '0;
      miss_cnt  <= '0;
      ovr_rel   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bub_cnt   <= bub_nxt;
      miss_cnt  <= miss_nxt;
      ovr_rel   <= ovr_rel_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Next-state and Mealy stage controls; a redirect overrides every state
  always_comb begin
    state_nxt   = state;
    bub_nxt     = bub_cnt;
    miss_nxt    = miss_cnt;
    ovr_rel_nxt = ovr_rel;
    timeout_nxt = timeout_q;
    p_pc        = 1'b0;
    p_if12      = 1'b0;
    p_if23      = 1'b0;
    f_if12      = 1'b0;
    f_if23      = 1'b0;
    load        = 1'b0;
    rescue      = 1'b0;

    if (bus.redirect_valid) begin
      load        = 1'b1;
      f_if12      = 1'b1;
      f_if23      = 1'b1;
      rescue      = bus.redirect_ds & bus.ds_in_if2;
      miss_nxt    = '0;
      ovr_rel_nxt = 1'b0;
      // A single-bubble redirect has no REDIR cycles: the redirect cycle is the bubble.
      if (REDIR_BUBBLES > 1) begin
        state_nxt = REDIR;
        bub_nxt   = BUB_LOAD;
      end else begin
        state_nxt = bus.icache_busy ? MISS : RUN;
        bub_nxt   = '0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (bus.backend_stall) begin
            p_pc   = 1'b1;
            p_if12 = 1'b1;
            p_if23 = 1'b1;
            if (bus.ovr_req) begin
              state_nxt   = OVR_HOLD;
              ovr_rel_nxt = 1'b0;
            end
          end else if (bus.ovr_req) begin
            // Replay of the saved bundle proceeds; a pending miss waits a cycle.
          end else if (bus.icache_busy) begin
            p_pc      = 1'b1;
            p_if12    = 1'b1;
            f_if23    = 1'b1;
            miss_nxt  = '0;
            state_nxt = MISS;
          end
        end
        MISS: begin
          if (bus.icache_busy) begin
            p_pc   = 1'b1;
            p_if12 = 1'b1;
            if (bus.backend_stall) p_if23 = 1'b1;
            else                   f_if23 = 1'b1;
            if (miss_cnt != '1) miss_nxt = miss_cnt + MISS_ONE;
            if (miss_nxt == '1) timeout_nxt = 1'b1;
          end else begin
            if (bus.backend_stall) begin
              p_pc   = 1'b1;
              p_if12 = 1'b1;
              p_if23 = 1'b1;
            end
            miss_nxt  = '0;
            state_nxt = RUN;
          end
        end
        OVR_HOLD: begin
          // ovr_rel marks that the stall-release (replay) cycle has happened.
          p_pc   = 1'b1;
          p_if12 = 1'b1;
          p_if23 = bus.backend_stall;
          if (bus.backend_stall) begin
            ovr_rel_nxt = 1'b0;
          end else if (!ovr_rel) begin
            ovr_rel_nxt = 1'b1;
          end else if (!bus.ovr_req) begin
            ovr_rel_nxt = 1'b0;
            state_nxt   = RUN;
          end
        end
        REDIR: begin
          f_if12  = 1'b1;
          bub_nxt = bub_cnt - 3'd1;
          if (bub_nxt == '0) state_nxt = bus.icache_busy ? MISS : RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held; flush wins over pause
  assign bus.pause_pc     = rst & p_pc;
  assign bus.pause_if12   = rst & p_if12 & ~f_if12;
  assign bus.pause_if23   = rst & p_if23 & ~f_if23;
  assign bus.flush_if12   = rst & f_if12;
  assign bus.flush_if23   = rst & f_if23;
  assign bus.pc_load      = rst & load;
  assign bus.rescue_ds    = rst & rescue;
  assign bus.miss_timeout = rst & timeout_q;

`ifdef IF_CTRL_PERF_EN
  // Wrapping event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
      perf_miss  <= '0;
      perf_redir <= '0;
    end else begin
      if (bus.backend_stall)  perf_stall <= perf_stall + 32'd1;
      if (state == MISS)      perf_miss  <= perf_miss + 32'd1;
      if (bus.redirect_valid) perf_redir <= perf_redir + 32'd1;
    end
  end
`else
`endif

endmodule
